// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges four functional-unit result channels into two ordered
// register-file write ports, buffering overflow in an in-order FIFO.
module wb_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          nClr,
    input  logic [3:0]    res_vld,
    input  logic [15:0]   res_wn,
    input  logic [127:0]  res_d,
    output logic          res_rdy,
    output logic          we1,
    output logic [3:0]    wn1,
    output logic [31:0]   d1,
    output logic          we2,
    output logic [3:0]    wn2,
    output logic [31:0]   d2,
    output logic [15:0]   pend_mask,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - 4);

    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] head_reg, head_next, tail_reg, tail_next, head_p1;
    logic [3:0]    fifo_wn [DEPTH];
    logic [31:0]   fifo_d  [DEPTH];

    logic [3:0]    ch_wn [4];
    logic [31:0]   ch_d  [4];
    logic [3:0]    acc_wn [4];
    logic [31:0]   acc_d  [4];
    logic [2:0]    n_acc, n_cand, pushed;
    logic [1:0]    fifo_avail, n_iss, popped, arr_iss;
    logic [3:0]    c1_wn, c2_wn;
    logic [31:0]   c1_d, c2_d;
    logic          iss1, iss2;
    logic [3:0]    push_en;
    logic [AW-1:0] push_idx [4];
    logic [15:0]   ent_mask [DEPTH];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            assign ch_wn[gi] = res_wn[4*gi +: 4];
            assign ch_d[gi]  = res_d[32*gi +: 32];
        end
    endgenerate

    // Ready looks only at the registered count so producers never see a combinational loop.
    assign res_rdy = nClr && (count_reg <= THRESH);
    assign head_p1 = head_reg + AW'(1);

    // Compact the accepted channels into arrival order.
    always_comb begin
        n_acc = 3'd0;
        for (int i = 0; i < 4; i++) begin
            acc_wn[i] = '0;
            acc_d[i]  = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (res_vld[i] && res_rdy) begin
                acc_wn[n_acc[1:0]] = ch_wn[i];
                acc_d[n_acc[1:0]]  = ch_d[i];
                n_acc = n_acc + 3'd1;
            end
        end
    end

    always_comb begin
        fifo_avail = (count_reg >= (AW+1)'(2)) ? 2'd2 : count_reg[1:0];
        c1_wn = '0;
        c1_d  = '0;
        c2_wn = '0;
        c2_d  = '0;
        if (fifo_avail != 2'd0) begin
            c1_wn = fifo_wn[head_reg];
            c1_d  = fifo_d[head_reg];
            if (fifo_avail == 2'd2) begin
                c2_wn = fifo_wn[head_p1];
                c2_d  = fifo_d[head_p1];
            end else begin
                c2_wn = acc_wn[0];
                c2_d  = acc_d[0];
            end
        end else begin
            c1_wn = acc_wn[0];
            c1_d  = acc_d[0];
            c2_wn = acc_wn[1];
            c2_d  = acc_d[1];
        end
        n_cand = {1'b0, fifo_avail} + n_acc;
        iss1   = (n_cand != 3'd0);
        iss2   = (n_cand >= 3'd2) && (c2_wn != c1_wn);
        n_iss  = {1'b0, iss1} + {1'b0, iss2};
        popped = (n_iss < fifo_avail) ? n_iss : fifo_avail;
        arr_iss = n_iss - popped;
        pushed = n_acc - {1'b0, arr_iss};
        // Arrivals behind the last issued candidate go to the FIFO tail in order.
        for (int j = 0; j < 4; j++) begin
            push_en[j]  = (3'(j) >= {1'b0, arr_iss}) && (3'(j) < n_acc);
            push_idx[j] = tail_reg + AW'(3'(j) - {1'b0, arr_iss});
        end
        count_next = count_reg + (AW+1)'(pushed) - (AW+1)'(popped);
        head_next  = head_reg + AW'(popped);
        tail_next  = tail_reg + AW'(pushed);
    end

    always_ff @(posedge clk or negedge nClr) begin
        if (!nClr) begin
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            we1 <= 1'b0;
            wn1 <= '0;
            d1  <= '0;
            we2 <= 1'b0;
            wn2 <= '0;
            d2  <= '0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            we1 <= iss1;
            wn1 <= iss1 ? c1_wn : '0;
            d1  <= iss1 ? c1_d : '0;
            we2 <= iss2;
            wn2 <= iss2 ? c2_wn : '0;
            d2  <= iss2 ? c2_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (push_en[j]) begin
                fifo_wn[push_idx[j]] <= acc_wn[j];
                fifo_d[push_idx[j]]  <= acc_d[j];
            end
        end
    end

    // An entry is live when its distance from head is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            logic [AW-1:0] offs;
            assign offs = AW'(gi) - head_reg;
            assign ent_mask[gi] = ({1'b0, offs} < count_reg) ? (16'd1 << fifo_wn[gi]) : 16'd0;
        end
    endgenerate

    always_comb begin
        pend_mask = (we1 ? (16'd1 << wn1) : 16'd0) | (we2 ? (16'd1 << wn2) : 16'd0);
        for (int k = 0; k < DEPTH; k++) begin
            pend_mask = pend_mask | ent_mask[k];
        end
    end

    assign busy = (count_reg != '0) || we1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: an ordered queue of accepted writes predicts
// both ports, pending mask, busy, ready and the final register-file contents.
module tb_wb_arbiter;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         nClr;
    logic [3:0]   res_vld;
    logic [15:0]  res_wn;
    logic [127:0] res_d;
    logic         res_rdy, we1, we2, busy;
    logic [3:0]   wn1, wn2;
    logic [31:0]  d1, d2;
    logic [15:0]  pend_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nClr(nClr),
        .res_vld(res_vld), .res_wn(res_wn), .res_d(res_d), .res_rdy(res_rdy),
        .we1(we1), .wn1(wn1), .d1(d1),
        .we2(we2), .wn2(wn2), .d2(d2),
        .pend_mask(pend_mask), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]  wn;
        logic [31:0] d;
    } wr_t;

    wr_t         q[$];
    logic        exp_we1, exp_we2;
    logic [3:0]  exp_wn1, exp_wn2;
    logic [31:0] exp_d1, exp_d2;
    logic [31:0] ref_rf [16];
    logic [31:0] dut_rf [16];
    logic [3:0]  last_acc;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vld_pct = 0;
    int wn_max = 15;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = 16'd0;
        foreach (q[k]) m = m | (16'd1 << q[k].wn);
        if (exp_we1) m = m | (16'd1 << exp_wn1);
        if (exp_we2) m = m | (16'd1 << exp_wn2);
        return m;
    endfunction

    task automatic clear_expect();
        exp_we1 = 1'b0; exp_wn1 = '0; exp_d1 = '0;
        exp_we2 = 1'b0; exp_wn2 = '0; exp_d2 = '0;
    endtask

    // Called at a falling edge: check what the last rising edge produced, then drive the next cycle.
    task automatic step();
        logic       rdy;
        logic [3:0] acc;
        wr_t        e;
        chk("we1", 32'(we1), 32'(exp_we1));
        chk("wn1", 32'(wn1), 32'(exp_wn1));
        chk("d1", d1, exp_d1);
        chk("we2", 32'(we2), 32'(exp_we2));
        chk("wn2", 32'(wn2), 32'(exp_wn2));
        chk("d2", d2, exp_d2);
        chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
        chk("busy", 32'(busy), 32'((q.size() != 0) || exp_we1));
        chk("res_rdy", 32'(res_rdy), 32'(q.size() <= DEPTH - 4));
        if (we1) begin
            dut_rf[wn1] = d1;
            $display("cyc %0d port1 r%0d <= %h", cyc, wn1, d1);
        end
        if (we2) begin
            dut_rf[wn2] = d2;
            $display("cyc %0d port2 r%0d <= %h", cyc, wn2, d2);
        end
        if (exp_we1) ref_rf[exp_wn1] = exp_d1;
        if (exp_we2) ref_rf[exp_wn2] = exp_d2;

        rdy = (q.size() <= DEPTH - 4);
        for (int i = 0; i < 4; i++) begin
            if (!(res_vld[i] && !last_acc[i])) begin
                res_vld[i] = ($urandom_range(99) < vld_pct);
                res_wn[4*i +: 4] = 4'($urandom_range(wn_max));
                res_d[32*i +: 32] = $urandom;
            end
        end
        acc = res_vld & {4{rdy}};
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                e.wn = res_wn[4*i +: 4];
                e.d  = res_d[32*i +: 32];
                q.push_back(e);
            end
        end
        clear_expect();
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_we1 = 1'b1; exp_wn1 = e.wn; exp_d1 = e.d;
            if (q.size() > 0 && q[0].wn != exp_wn1) begin
                e = q.pop_front();
                exp_we2 = 1'b1; exp_wn2 = e.wn; exp_d2 = e.d;
            end
        end
        last_acc = acc;
        @(negedge clk);
        cyc++;
    endtask

    task automatic mid_reset();
        $display("cyc %0d reset with %0d queued, we1=%0b", cyc, q.size(), we1);
        #2 nClr = 1'b0;
        #1;
        chk("rst_we1", 32'(we1), 32'd0);
        chk("rst_we2", 32'(we2), 32'd0);
        chk("rst_wn1", 32'(wn1), 32'd0);
        chk("rst_d1", d1, 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(res_rdy), 32'd0);
        res_vld = '0;
        last_acc = '0;
        q.delete();
        clear_expect();
        @(negedge clk);
        @(negedge clk);
        nClr = 1'b1;
        #1;
        chk("rel_rdy", 32'(res_rdy), 32'd1);
        chk("rel_we1", 32'(we1), 32'd0);
    endtask

    initial begin
        nClr = 1'b0;
        res_vld = '0;
        res_wn = '0;
        res_d = '0;
        last_acc = '0;
        clear_expect();
        for (int r = 0; r < 16; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
        repeat (2) @(negedge clk);
        chk("init_we1", 32'(we1), 32'd0);
        chk("init_rdy", 32'(res_rdy), 32'd0);
        nClr = 1'b1;
        #1;
        chk("init_rel_rdy", 32'(res_rdy), 32'd1);

        vld_pct = 95; wn_max = 15;
        repeat (60) step();
        mid_reset();
        vld_pct = 70; wn_max = 1;
        repeat (150) step();
        vld_pct = 30; wn_max = 15;
        repeat (150) step();
        vld_pct = 100; wn_max = 3;
        repeat (40) step();
        vld_pct = 0;
        repeat (20) step();

        chk("final_busy", 32'(busy), 32'd0);
        for (int r = 0; r < 16; r++) chk($sformatf("rf%0d", r), dut_rf[r], ref_rf[r]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Writeback arbiter sitting directly upstream of the 16 x 32-bit, two-write-port register file.
- Collects results from four functional-unit channels (FP add, FP mul, integer ALU, load) and buffers any overflow in an in-order FIFO.
- Drives at most two register writes per cycle onto the register file's write ports, from a registered output stage.
- Guarantees the two ports never target the same register in one cycle, and that writes to any register retire in arrival order.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- nClr  in  1  asynchronous active-low reset.
- res_vld  in  4  per-channel result valid; channel i = bit i.
- res_wn  in  16  destination register; channel i at [4i+3:4i].
- res_d  in  128  result data; channel i at [32i+31:32i].
- res_rdy  out  1  common ready for all channels.
- we1, wn1[3:0], d1[31:0]  out  port-1 write enable, register, data (older write).
- we2, wn2[3:0], d2[31:0]  out  port-2 write enable, register, data (younger write).
- pend_mask  out  16  bit r set while any FIFO or output-stage entry targets register r.
- busy  out  1  FIFO non-empty or we1/we2 asserted.

## Operation
- Handshake
  - Channel i is accepted in a cycle iff res_vld[i] && res_rdy.
  - res_rdy = nClr && (count ≤ DEPTH−4). It depends only on registered count, never on res_vld.
  - A producer holds vld, wn and d stable until accepted.
- Candidate order each cycle, oldest first:
  - FIFO[head], then FIFO[head+1];
  - then accepted channels in order ch0, ch1, ch2, ch3.
- Issue into the output stage (strictly in order)
  - Candidate 1 → port 1.
  - Candidate 2 → port 2 only if its wn differs from candidate 1's wn.
  - Otherwise only one write issues this cycle, and candidate 2 and everything behind it wait.
  - Nothing ever overtakes a skipped candidate.
- Non-issued accepted arrivals are pushed into the FIFO in candidate order.
- Count: count_next = count + pushed − popped; count is 0..DEPTH and is (log2 DEPTH)+1 bits wide.
  - The threshold guarantees no overflow: worst case (DEPTH−4) + 4 − 0 ≤ DEPTH.
- FIFO uses head and tail pointers that wrap modulo DEPTH; full and empty are decided from count, not from pointer equality.
- Output-stage registers hold we/wn/d for exactly one cycle per issue.
  - we1=0 implies we2=0.
  - wn/d are don't-care when the corresponding we is 0, but are driven to 0.
- pend_mask is combinational OR-decode of all valid FIFO entries plus the output-stage entries whose we is set.

## Timing
- Latency: a channel accepted in cycle n with an empty FIFO appears on we1/we2 in cycle n+1 and is written into the register file at the end of cycle n+1.
- Buffered entries issue on the first cycle they reach the candidate-1 or candidate-2 position.
- Throughput: 2 writes/cycle with distinct destinations; 1/cycle for back-to-back same-register writes.
- Reset (nClr low, asynchronous, any time including mid-drain):
  - count=0, pointers=0, FIFO contents discarded.
  - we1=we2=0, wn1=wn2=0, d1=d2=0, pend_mask=0, busy=0, res_rdy=0.
- After nClr rises, res_rdy=1 in the same cycle.
- Empty FIFO with no valids: we1=we2=0 next cycle.
- FIFO with exactly 1 entry plus arrivals: FIFO[head] → port 1, first accepted channel → port 2 (subject to the same-register rule).

## Test plan
- Reset: assert nClr while 4 entries are buffered and we1=1 → same-cycle we1=we2=0, pend_mask=0, busy=0, res_rdy=0; release → res_rdy=1, no writes.
- Single write: ch2 vld, wn=5, d=0x3F800000 in cycle n → cycle n+1 we1=1, wn1=5, d1=0x3F800000, we2=0; pend_mask=0x0020 in n+1 only.
- Four distinct: ch0..ch3 wn=1,2,3,4 in cycle n → n+1 ports (1,2), n+2 ports (3,4); count=2 after n; busy low in n+3.
- Same register: ch0 wn=7 d=0xA, ch1 wn=7 d=0xB in cycle n → n+1 we1 wn1=7 d1=0xA, we2=0; n+2 we1 wn1=7 d1=0xB, we2=0; register 7 ends at 0xB.
- Backpressure (DEPTH=8): all four channels valid every cycle from empty → count 0→2→4→6; res_rdy drops at count 6; drains 2 per cycle; res_rdy returns at count ≤4; all results written once, in order.
- Held valid: ch1 valid while res_rdy=0 for 3 cycles → not accepted or written; accepted in the first cycle res_rdy=1 and written exactly once, the following cycle or later.
